// File: rtl/cnt_checker_pkg.sv
// cnt_checker_pkg: counter encodings shared by the adder4 counter and its sequence checker
package cnt_checker_pkg;
  localparam int CNT_WIDTH = 4;
  localparam int RUN_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, LOCKED = 2'd2} state_t;
endpackage

// File: rtl/cnt_checker_sat_counter.sv
// sat_counter: saturating event counter, clear wins over increment
module sat_counter #(
  parameter int ERRW = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            inc,
  input  logic            clr,
  output logic [ERRW-1:0] cnt
);
  always_ff @(posedge CLK or posedge RST)
    if (RST) cnt <= '0;
    else cnt <= clr ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/cnt_checker.sv
// cnt_checker: locks onto an incrementing counter and counts sequence breaks once locked
module cnt_checker
  import cnt_checker_pkg::*;
#(
  parameter int WIDTH    = CNT_WIDTH,
  parameter int LOCK_LEN = 3,
  parameter int ERRW     = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             I_EN,
  input  logic [WIDTH-1:0] I_CNT,
  input  logic             I_CLR,
  output logic             O_LOCKED,
  output logic             O_ERR,
  output logic [ERRW-1:0]  O_ERR_CNT,
  output logic [WIDTH-1:0] O_EXPECT
);
  state_t           state;
  logic [RUN_W-1:0] run;
  logic             match;
  logic             err;
  assign match = I_CNT == O_EXPECT;
  assign err   = I_EN && state == LOCKED && !match;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state    <= IDLE;
      run      <= '0;
      O_LOCKED <= 1'b0;
      O_ERR    <= 1'b0;
      O_EXPECT <= '0;
    end else begin
      O_ERR <= err;
      if (I_EN) begin
        O_EXPECT <= I_CNT + 1'b1;
        case (state)
          IDLE: begin
            state <= SYNC;
            run   <= '0;
          end
          SYNC:
            if (!match) run <= '0;
            else if (run == RUN_W'(LOCK_LEN - 1)) begin
              state    <= LOCKED;
              run      <= '0;
              O_LOCKED <= 1'b1;
            end else run <= run + 1'b1;
          LOCKED:
            if (!match) begin
              state    <= SYNC;
              run      <= '0;
              O_LOCKED <= 1'b0;
            end
          default: begin
            state    <= IDLE;
            run      <= '0;
            O_LOCKED <= 1'b0;
          end
        endcase
      end
    end
  sat_counter #(.ERRW(ERRW)) u_err_cnt (
    .CLK(CLK),
    .RST(RST),
    .inc(err),
    .clr(I_CLR),
    .cnt(O_ERR_CNT)
  );
endmodule

// File: tb/tb_cnt_checker.sv
// tb_cnt_checker: directed scenarios plus random traffic against a sample-level reference model
module tb_cnt_checker;
  localparam int LOCK_LEN = 3;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       I_EN = 1'b0;
  logic [3:0] I_CNT = '0;
  logic       I_CLR = 1'b0;
  logic       o_locked, o_err, o_locked2, o_err2;
  logic [7:0] o_err_cnt;
  logic [1:0] o_err_cnt2;
  logic [3:0] o_expect, o_expect2;
  int n_chk = 0;
  int n_err = 0;
  bit m_has, m_lock, m_err;
  int m_run, m_exp, e8, e2;

  cnt_checker #(.WIDTH(4), .LOCK_LEN(LOCK_LEN), .ERRW(8)) dut (
    .CLK(CLK), .RST(RST), .I_EN(I_EN), .I_CNT(I_CNT), .I_CLR(I_CLR),
    .O_LOCKED(o_locked), .O_ERR(o_err), .O_ERR_CNT(o_err_cnt), .O_EXPECT(o_expect)
  );
  cnt_checker #(.WIDTH(4), .LOCK_LEN(LOCK_LEN), .ERRW(2)) dut2 (
    .CLK(CLK), .RST(RST), .I_EN(I_EN), .I_CNT(I_CNT), .I_CLR(I_CLR),
    .O_LOCKED(o_locked2), .O_ERR(o_err2), .O_ERR_CNT(o_err_cnt2), .O_EXPECT(o_expect2)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_has = 0; m_lock = 0; m_err = 0; m_run = 0; m_exp = 0; e8 = 0; e2 = 0;
  endtask

  task automatic model(input bit en, input int c, input bit clr);
    m_err = 0;
    if (en) begin
      if (!m_has) begin
        m_has = 1;
        m_run = 0;
      end else if (m_lock) begin
        if (c != m_exp) begin
          m_err = 1;
          m_lock = 0;
          m_run = 0;
        end
      end else if (c == m_exp) begin
        m_run++;
        if (m_run == LOCK_LEN) begin
          m_lock = 1;
          m_run = 0;
        end
      end else m_run = 0;
      m_exp = (c + 1) % 16;
    end
    if (m_err) begin
      e8 = e8 < 255 ? e8 + 1 : e8;
      e2 = e2 < 3 ? e2 + 1 : e2;
    end
    if (clr) begin
      e8 = 0;
      e2 = 0;
    end
  endtask

  task automatic step(input bit en, input int c, input bit clr);
    I_EN = en;
    I_CNT = 4'(c);
    I_CLR = clr;
    @(posedge CLK);
    model(en, c, clr);
    #1;
    chk("locked", o_locked, m_lock);
    chk("err", o_err, m_err);
    chk("expect", o_expect, m_exp);
    chk("err_cnt", o_err_cnt, e8);
    chk("err_cnt_w2", o_err_cnt2, e2);
    chk("err_w2", o_err2, m_err);
  endtask

  initial begin
    int pulses;
    model_reset();
    #20;
    chk("rst_locked", o_locked, 0);
    chk("rst_err", o_err, 0);
    chk("rst_err_cnt", o_err_cnt, 0);
    chk("rst_expect", o_expect, 0);
    #10 RST = 1'b0;
    // adder4 count: lock after the sample of 3
    for (int i = 0; i <= 4; i++) step(1, i, 0);
    chk("b1_locked", o_locked, 1);
    chk("b1_err_cnt", o_err_cnt, 0);
    // climb to 14 and wrap through 15, 0, 1
    for (int i = 5; i <= 17; i++) begin
      step(1, i % 16, 0);
      chk("b2_no_err", o_err, 0);
    end
    chk("b2_locked", o_locked, 1);
    // break sequence: 5 where 7 is expected
    for (int i = 2; i <= 6; i++) step(1, i, 0);
    step(1, 5, 0);
    chk("b3_err", o_err, 1);
    chk("b3_cnt", o_err_cnt, 1);
    chk("b3_locked", o_locked, 0);
    chk("b3_expect", o_expect, 6);
    step(1, 6, 0);
    chk("b3_pulse_one", o_err, 0);
    step(1, 7, 0);
    step(1, 8, 0);
    chk("b3_relock", o_locked, 1);
    // disabled cycles with garbage on I_CNT
    for (int i = 0; i < 4; i++) step(0, $urandom_range(15), 0);
    step(1, 9, 0);
    chk("b4_locked", o_locked, 1);
    chk("b4_err_cnt", o_err_cnt, 1);
    // five forced errors, relocking in between
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      step(1, (m_exp + 3) % 16, 0);
      pulses += o_err2;
      for (int j = 0; j < 3; j++) step(1, m_exp, 0);
    end
    chk("b5_pulses", pulses, 5);
    chk("b5_sat", o_err_cnt2, 3);
    chk("b5_cnt8", o_err_cnt, 6);
    step(1, (m_exp + 5) % 16, 1);
    chk("b5_clr_err", o_err, 1);
    chk("b5_clr_cnt", o_err_cnt2, 0);
    for (int j = 0; j < 3; j++) step(1, m_exp, 0);
    chk("b6_pre_locked", o_locked, 1);
    // asynchronous reset between edges
    #2 RST = 1'b1;
    #1;
    chk("b6_locked", o_locked, 0);
    chk("b6_expect", o_expect, 0);
    chk("b6_cnt", o_err_cnt, 0);
    model_reset();
    #2 RST = 1'b0;
    step(1, 11, 0);
    chk("b6_base_expect", o_expect, 12);
    chk("b6_base_err", o_err, 0);
    for (int i = 0; i < 400; i++) begin
      bit en, clr;
      int c;
      en = $urandom_range(3) != 0;
      clr = $urandom_range(19) == 0;
      c = $urandom_range(9) < 7 ? m_exp : $urandom_range(15);
      step(en, c, clr);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
